// File: rtl/mix_col_seq.sv
// mix_col_seq: sequential AES MixColumns / InvMixColumns engine.
// Takes a state of NB 32-bit columns and transforms COLS_PER_CYCLE columns per clock.
// The state is held in a work register and updated in place. The finished state is copied
// into a separate output register, so out_data keeps its value until the next result arrives.
// Build option: define MIX_COL_INV_EN to build the InvMixColumns datapath. When it is not
// defined, in_inv is ignored and the forward transform is always applied.
// Column c sits at data[32*(NB-c)-1 -: 32]. Row 0 of a column is its most significant byte.

module mix_col_seq #(
   parameter int unsigned NB             = 4,
   parameter int unsigned COLS_PER_CYCLE = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [32*NB-1:0]  in_data,
   input  logic              in_inv,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [32*NB-1:0]  out_data,
   output logic              busy
);

   localparam int unsigned DataW  = 32 * NB;
   localparam int unsigned NumGrp = NB / COLS_PER_CYCLE;
   localparam int unsigned IdxW   = (NumGrp > 1) ? $clog2(NumGrp) : 1;
   localparam logic [IdxW-1:0] LastGrp = IdxW'(NumGrp - 1);

   // COLS_PER_CYCLE must split the state into whole column groups.
   if ((COLS_PER_CYCLE == 0) || ((NB % COLS_PER_CYCLE) != 0)) begin : g_bad_cfg
      $error("mix_col_seq: COLS_PER_CYCLE must be non-zero and divide NB");
   end

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e             r_state;
   logic [DataW-1:0]   r_work;
   logic [DataW-1:0]   r_out_data;
   logic [IdxW-1:0]    r_col_idx;    // index of the column group, not of the column
   logic               r_in_ready;
   logic               r_out_valid;
   logic               r_busy;
   logic [DataW-1:0]   w_work_next;
   int unsigned        w_hi;

`ifdef MIX_COL_INV_EN
   logic               r_inv;
`else
   logic               w_unused_inv;
   assign w_unused_inv = in_inv;
`endif

   // ---------------------------------------------------------------------------------------------
   // GF(2^8) helpers. Multiply only by the fixed MixColumns constants.
   // ---------------------------------------------------------------------------------------------
   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] mul03(input logic [7:0] x);
      return xtime(x) ^ x;
   endfunction

   // Forward transform of one column, rows {2,3,1,1} rotated by row.
   function automatic logic [31:0] mix_fwd(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      logic [7:0] b0, b1, b2, b3;
      a0 = c[31:24];
      a1 = c[23:16];
      a2 = c[15:8];
      a3 = c[7:0];
      b0 = xtime(a0) ^ mul03(a1) ^ a2 ^ a3;
      b1 = a0 ^ xtime(a1) ^ mul03(a2) ^ a3;
      b2 = a0 ^ a1 ^ xtime(a2) ^ mul03(a3);
      b3 = mul03(a0) ^ a1 ^ a2 ^ xtime(a3);
      return {b0, b1, b2, b3};
   endfunction

`ifdef MIX_COL_INV_EN
   // Shared xtime chain: x8 ^ x = 9, x8 ^ x2 ^ x = b, x8 ^ x4 ^ x = d, x8 ^ x4 ^ x2 = e.
   function automatic logic [7:0] mul09(input logic [7:0] x);
      return xtime(xtime(xtime(x))) ^ x;
   endfunction

   function automatic logic [7:0] mul0b(input logic [7:0] x);
      return xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
   endfunction

   function automatic logic [7:0] mul0d(input logic [7:0] x);
      return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
   endfunction

   function automatic logic [7:0] mul0e(input logic [7:0] x);
      return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
   endfunction

   // Inverse transform of one column, rows {e,b,d,9} rotated by row.
   function automatic logic [31:0] mix_inv(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      logic [7:0] b0, b1, b2, b3;
      a0 = c[31:24];
      a1 = c[23:16];
      a2 = c[15:8];
      a3 = c[7:0];
      b0 = mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3);
      b1 = mul09(a0) ^ mul0e(a1) ^ mul0b(a2) ^ mul0d(a3);
      b2 = mul0d(a0) ^ mul09(a1) ^ mul0e(a2) ^ mul0b(a3);
      b3 = mul0b(a0) ^ mul0d(a1) ^ mul09(a2) ^ mul0e(a3);
      return {b0, b1, b2, b3};
   endfunction
`endif

   // ---------------------------------------------------------------------------------------------
   // Datapath
   // ---------------------------------------------------------------------------------------------

   // Transform the current column group in place; every other column passes through.
   always_comb begin
      w_work_next = r_work;
      w_hi        = 0;
      for (int unsigned k = 0; k < COLS_PER_CYCLE; k++) begin
         w_hi = DataW - 1 - 32 * (COLS_PER_CYCLE * 32'(r_col_idx) + k);
`ifdef MIX_COL_INV_EN
         w_work_next[w_hi -: 32] = r_inv ? mix_inv(r_work[w_hi -: 32])
                                         : mix_fwd(r_work[w_hi -: 32]);
`else
         w_work_next[w_hi -: 32] = mix_fwd(r_work[w_hi -: 32]);
`endif
      end
   end

   // ---------------------------------------------------------------------------------------------
   // Control
   // ---------------------------------------------------------------------------------------------

   // Control FSM with registered handshake outputs; reset aborts any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= StIdle;
         r_work      <= '0;
         r_out_data  <= '0;
         r_col_idx   <= '0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
`ifdef MIX_COL_INV_EN
         r_inv       <= 1'b0;
`endif
      end else begin
         unique case (r_state)
            StIdle: begin
               // in_ready is still low in the first cycle after reset, so gate on it.
               r_in_ready <= 1'b1;
               if (in_valid && r_in_ready) begin
                  r_work     <= in_data;
`ifdef MIX_COL_INV_EN
                  r_inv      <= in_inv;
`endif
                  r_col_idx  <= '0;
                  r_in_ready <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= StBusy;
               end
            end
            StBusy: begin
               r_work <= w_work_next;
               if (r_col_idx == LastGrp) begin
                  r_col_idx   <= '0;
                  r_out_data  <= w_work_next;
                  r_out_valid <= 1'b1;
                  r_state     <= StDone;
               end else begin
                  r_col_idx <= r_col_idx + 1'b1;
               end
            end
            StDone: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_busy      <= 1'b0;
                  r_state     <= StIdle;
               end
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign busy      = r_busy;

`ifndef SYNTHESIS
   // Capture and release live in different states, so the two handshakes never overlap.
   a_no_overlap: assert property (@(posedge clk) disable iff (rst) !(in_ready && out_valid));
   a_busy_blocks_input: assert property (@(posedge clk) disable iff (rst) busy |-> !in_ready);
`endif

endmodule

// File: tb/tb_mix_col_seq.sv
// Self-checking bench for mix_col_seq.
// Expected results come from a byte-matrix model using generic GF(2^8) multiplication.
// A driver pushes expected data and the accept cycle into queues; monitors pop and compare.
// Extra instances cover other NB / COLS_PER_CYCLE combinations.

module tb_mix_col_seq;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic         in_inv;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;
   logic         busy;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   logic [127:0] exp_q[$];
   int           lat_q[$];
   logic         prev_valid;

   localparam int MainGrp = 4;

   mix_col_seq #(
      .NB             (4),
      .COLS_PER_CYCLE (1)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_inv    (in_inv),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #800000;
      $display("FAIL watchdog: got no completion, required finish before time limit");
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------------------------
   function automatic void chk(input bit ok, input string name, input logic [255:0] act,
                               input logic [255:0] expv);
      n_checks++;
      if (!ok) begin
         n_errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, expv);
      end
   endfunction

   // Shift-and-add multiply in GF(2^8) with the AES polynomial.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      logic [7:0] y;
      p = 8'h00;
      x = a;
      y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [31:0] ref_col(input logic [31:0] c, input bit inv);
      logic [7:0]  co[4];
      logic [7:0]  a[4];
      logic [7:0]  r;
      logic [31:0] res;
      if (inv) co = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      else     co = '{8'h02, 8'h03, 8'h01, 8'h01};
      for (int i = 0; i < 4; i++) a[i] = c[31-8*i -: 8];
      res = '0;
      for (int row = 0; row < 4; row++) begin
         r = 8'h00;
         for (int j = 0; j < 4; j++) r = r ^ gmul(co[(j - row + 4) % 4], a[j]);
         res[31-8*row -: 8] = r;
      end
      return res;
   endfunction

   function automatic logic [127:0] ref_state4(input logic [127:0] s, input bit inv);
      logic [127:0] r;
      for (int c = 0; c < 4; c++) r[127-32*c -: 32] = ref_col(s[127-32*c -: 32], inv);
      return r;
   endfunction

   // The inverse select only matters when the inverse datapath is built.
   function automatic bit eff_inv(input bit inv);
`ifdef MIX_COL_INV_EN
      return inv;
`else
      return 1'b0;
`endif
   endfunction

   // ---------------------------------------------------------------------------------------------
   // Main instance: driver tasks and monitor
   // ---------------------------------------------------------------------------------------------
   task automatic send(input logic [127:0] d, input logic inv, input logic [127:0] expv);
      int t;
      t = 0;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = d;
      in_inv   = inv;
      @(negedge clk);
      while (!in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk(in_ready == 1'b1, "input_accept", in_ready, 1);
      if (in_ready) begin
         exp_q.push_back(expv);
         lat_q.push_back(cyc + 1);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output logic [127:0] d);
      int t;
      t = 0;
      while (!out_valid && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk(out_valid == 1'b1, "out_valid_timeout", out_valid, 1);
      d = out_data;
   endtask

   task automatic drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk(exp_q.size() == 0, "drain", exp_q.size(), 0);
   endtask

   // Scoreboard monitor: latency on each rising out_valid, data on each output handshake.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && !prev_valid) begin
            if (lat_q.size() == 0) begin
               chk(1'b0, "unexpected_valid", out_valid, 0);
            end else begin
               int a;
               a = lat_q.pop_front();
               chk(cyc - a == MainGrp, "latency", cyc - a, MainGrp);
            end
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk(1'b0, "unexpected_output", out_data, 0);
            end else begin
               logic [127:0] e;
               e = exp_q.pop_front();
               chk(out_data == e, "out_data", out_data, e);
            end
         end
      end
      prev_valid <= out_valid;
   end

   // ---------------------------------------------------------------------------------------------
   // Sweep instances with random backpressure
   // ---------------------------------------------------------------------------------------------
   for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
      localparam int SNb  = (gi == 2) ? 8 : 4;
      localparam int SCpc = (gi == 1) ? 4 : 2;
      localparam int SW   = 32 * SNb;
      localparam int SGrp = SNb / SCpc;

      logic          s_rst;
      logic          s_in_valid;
      logic          s_in_ready;
      logic [SW-1:0] s_in_data;
      logic          s_in_inv;
      logic          s_out_valid;
      logic          s_out_ready;
      logic [SW-1:0] s_out_data;
      logic          s_busy;
      logic          s_prev_valid;
      bit            s_done = 1'b0;
      logic [SW-1:0] s_exp_q[$];
      int            s_lat_q[$];

      mix_col_seq #(
         .NB             (SNb),
         .COLS_PER_CYCLE (SCpc)
      ) u_dut (
         .clk       (clk),
         .rst       (s_rst),
         .in_valid  (s_in_valid),
         .in_ready  (s_in_ready),
         .in_data   (s_in_data),
         .in_inv    (s_in_inv),
         .out_valid (s_out_valid),
         .out_ready (s_out_ready),
         .out_data  (s_out_data),
         .busy      (s_busy)
      );

      function automatic logic [SW-1:0] ref_state(input logic [SW-1:0] s, input bit inv);
         logic [SW-1:0] r;
         for (int c = 0; c < SNb; c++) r[SW-1-32*c -: 32] = ref_col(s[SW-1-32*c -: 32], inv);
         return r;
      endfunction

      initial begin
         s_out_ready = 1'b1;
         forever begin
            @(posedge clk);
            #1;
            s_out_ready = ($urandom_range(0, 3) != 0);
         end
      end

      initial begin
         logic [SW-1:0] d;
         bit            inv;
         int            t;
         s_rst      = 1'b1;
         s_in_valid = 1'b0;
         s_in_data  = '0;
         s_in_inv   = 1'b0;
         repeat (3) @(posedge clk);
         #1;
         s_rst = 1'b0;
         for (int n = 0; n < 40; n++) begin
            for (int w = 0; w < SNb; w++) d[32*w +: 32] = $urandom;
            inv        = 1'($urandom_range(0, 1));
            s_in_valid = 1'b1;
            s_in_data  = d;
            s_in_inv   = inv;
            t          = 0;
            @(negedge clk);
            while (!s_in_ready && t < 200) begin
               @(negedge clk);
               t++;
            end
            chk(s_in_ready == 1'b1, "sweep_accept", s_in_ready, 1);
            if (s_in_ready) begin
               s_exp_q.push_back(ref_state(d, eff_inv(inv)));
               s_lat_q.push_back(cyc + 1);
            end
            @(posedge clk);
            #1;
            s_in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
         end
         t = 0;
         while (s_exp_q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
         end
         chk(s_exp_q.size() == 0, "sweep_drain", s_exp_q.size(), 0);
         s_done = 1'b1;
      end

      always @(negedge clk) begin
         if (!s_rst) begin
            if (s_out_valid && !s_prev_valid) begin
               if (s_lat_q.size() == 0) begin
                  chk(1'b0, "sweep_unexpected_valid", s_out_valid, 0);
               end else begin
                  int a;
                  a = s_lat_q.pop_front();
                  chk(cyc - a == SGrp, "sweep_latency", cyc - a, SGrp);
               end
            end
            if (s_out_valid && s_out_ready) begin
               if (s_exp_q.size() == 0) begin
                  chk(1'b0, "sweep_unexpected_output", s_out_data, 0);
               end else begin
                  logic [SW-1:0] e;
                  e = s_exp_q.pop_front();
                  chk(s_out_data == e, "sweep_out_data", s_out_data, e);
               end
            end
         end
         s_prev_valid <= s_out_valid;
      end
   end

   // ---------------------------------------------------------------------------------------------
   // Main sequence
   // ---------------------------------------------------------------------------------------------
   initial begin
      logic [127:0] s;
      logic [127:0] d;
      logic [127:0] d0;
      int           t;
      bit           inv;

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_inv    = 1'b0;
      out_ready = 1'b1;

      // Reset values.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk(in_ready == 1'b0, "rst_in_ready", in_ready, 0);
      chk(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
      chk(busy == 1'b0, "rst_busy", busy, 0);
      chk(out_data == '0, "rst_out_data", out_data, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk(in_ready == 1'b0, "in_ready_before_first_edge", in_ready, 0);
      @(negedge clk);
      chk(in_ready == 1'b1, "in_ready_after_rst", in_ready, 1);

      // Known vector, in_ready low until the result appears.
      send({4{32'hdb135345}}, 1'b0, {4{32'h8e4da1bc}});
      t = 0;
      while (!out_valid && t < 20) begin
         chk(in_ready == 1'b0, "in_ready_busy", in_ready, 0);
         chk(busy == 1'b1, "busy_high", busy, 1);
         @(negedge clk);
         t++;
      end
      drain();

      // Four distinct columns.
      send(128'hf20a225c_01010101_c6c6c6c6_d4d4d4d5, 1'b0,
           128'h9fdc589d_01010101_c6c6c6c6_d5d5d7d6);
      drain();

`ifdef MIX_COL_INV_EN
      send({4{32'h8e4da1bc}}, 1'b1, {4{32'hdb135345}});
      drain();
      // Forward results go back through the inverse and must recover the original state.
      for (int n = 0; n < 1000; n++) begin
         for (int w = 0; w < 4; w++) s[32*w +: 32] = $urandom;
         send(s, 1'b0, ref_state4(s, 1'b0));
         wait_out(d);
         send(d, 1'b1, s);
         wait_out(d);
      end
      drain();
`else
      // Without the inverse datapath in_inv has no effect.
      send({4{32'hdb135345}}, 1'b1, {4{32'h8e4da1bc}});
      drain();
      for (int n = 0; n < 200; n++) begin
         for (int w = 0; w < 4; w++) s[32*w +: 32] = $urandom;
         inv = 1'($urandom_range(0, 1));
         send(s, inv, ref_state4(s, eff_inv(inv)));
         wait_out(d);
      end
      drain();
`endif

      // Backpressure: hold out_ready low for 10 cycles in DONE.
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      for (int w = 0; w < 4; w++) s[32*w +: 32] = $urandom;
      send(s, 1'b0, ref_state4(s, 1'b0));
      wait_out(d0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk(out_valid == 1'b1, "hold_out_valid", out_valid, 1);
         chk(out_data == d0, "hold_out_data", out_data, d0);
         chk(in_ready == 1'b0, "hold_in_ready", in_ready, 0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk(out_valid == 1'b0, "release_out_valid", out_valid, 0);
      chk(in_ready == 1'b1, "release_in_ready", in_ready, 1);
      chk(out_data == ref_state4(s, 1'b0), "release_keeps_data", out_data,
          ref_state4(s, 1'b0));
      drain();

      // Reset in the second BUSY cycle aborts the operation.
      for (int w = 0; w < 4; w++) s[32*w +: 32] = $urandom;
      send(s, 1'b0, ref_state4(s, 1'b0));
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk(out_valid == 1'b0, "abort_out_valid", out_valid, 0);
      chk(out_data == '0, "abort_out_data", out_data, 0);
      chk(in_ready == 1'b0, "abort_in_ready", in_ready, 0);
      exp_q.delete();
      lat_q.delete();
      rst = 1'b0;
      @(negedge clk);
      chk(in_ready == 1'b1, "abort_in_ready_rise", in_ready, 1);
      for (int w = 0; w < 4; w++) s[32*w +: 32] = $urandom;
      send(s, 1'b0, ref_state4(s, 1'b0));
      wait_out(d);
      drain();

      // Wait for the sweep instances.
      t = 0;
      while (!(g_sweep[0].s_done && g_sweep[1].s_done && g_sweep[2].s_done) && t < 5000) begin
         @(negedge clk);
         t++;
      end
      chk(g_sweep[0].s_done && g_sweep[1].s_done && g_sweep[2].s_done, "sweep_complete",
          {g_sweep[2].s_done, g_sweep[1].s_done, g_sweep[0].s_done}, 3'b111);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
